serial_subtractor: RTL and testbench

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

---
 rtl/serial_subtractor.sv | 107 ++++++++++
 tb/tb_serial_subtractor.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial a-b subtractor with valid/ready handshakes, borrow and overflow flags
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int CW = (WIDTH < 2) ? 1 : $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sh, b_sh, res;
  logic [CW-1:0]    cnt;
  logic             br, a_msb, b_msb;

  logic             in_xfer, last_bit;
  logic             ai, bi, d, br_nxt;
  logic [WIDTH:0]   res_cat;
  logic [WIDTH-1:0] res_nxt;

  // in_ready is a registered copy of "next state is IDLE", so it stays low
  // during reset and has no path from any input.
  assign in_xfer   = in_valid & in_ready;
  assign last_bit  = (state == RUN) && (cnt == LAST);
  assign out_valid = (state == DONE);

  // Full-subtractor cell on the current LSBs; new bits enter the result at the MSB.
  assign ai      = a_sh[0];
  assign bi      = b_sh[0];
  assign d       = ai ^ bi ^ br;
  assign br_nxt  = (~ai & bi) | (~(ai ^ bi) & br);
  assign res_cat = {d, res};
  assign res_nxt = res_cat[WIDTH:1];

  // State register and registered in_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      in_ready <= 1'b0;
    end else begin
      state    <= state_nxt;
      in_ready <= (state_nxt == IDLE);
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_xfer) state_nxt = RUN;
      RUN:     if (last_bit) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture, one bit per RUN cycle, and result load on the final bit;
  // result outputs are untouched outside that load so they hold after delivery.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh  <= '0;
      b_sh  <= '0;
      res   <= '0;
      cnt   <= '0;
      br    <= 1'b0;
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      diff  <= '0;
      bout  <= 1'b0;
      ovf   <= 1'b0;
    end else if (state == IDLE) begin
      if (in_xfer) begin
        a_sh  <= a;
        b_sh  <= b;
        res   <= '0;
        cnt   <= '0;
        br    <= 1'b0;
        a_msb <= a[WIDTH-1];
        b_msb <= b[WIDTH-1];
      end
    end else if (state == RUN) begin
      a_sh <= a_sh >> 1;
      b_sh <= b_sh >> 1;
      res  <= res_nxt;
      br   <= br_nxt;
      cnt  <= cnt + CW'(1);
      if (last_bit) begin
        diff <= res_nxt;
        bout <= br_nxt;
        ovf  <= (a_msb ^ b_msb) & (res_nxt[WIDTH-1] ^ a_msb);
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - scoreboard bench for serial_subtractor against an arithmetic reference
module tb_serial_subtractor;

  localparam int W   = 8;
  localparam int LAT = W;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] diff;
  logic         bout;
  logic         ovf;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int n_acc = 0;
  logic [W+1:0] exp_q[$];
  int           acc_q[$];

  serial_subtractor #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .diff(diff), .bout(bout), .ovf(ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y);
    int sx, sy, sd;
    logic [W-1:0] dd;
    logic bo, ov;
    sx = $signed(x);
    sy = $signed(y);
    sd = sx - sy;
    dd = W'(int'(x) - int'(y));
    bo = (int'(x) < int'(y));
    ov = (sd > (2 ** (W - 1)) - 1) || (sd < -(2 ** (W - 1)));
    return {dd, bo, ov};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor/scoreboard: samples on the falling edge, away from the active edge.
  initial begin
    logic prev_ov;
    logic [W+1:0] e;
    int t;
    prev_ov = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_ov = 1'b0;
      end else begin
        if (in_valid && in_ready) begin
          exp_q.push_back(model(a, b));
          acc_q.push_back(cyc + 1);
          n_acc++;
        end
        if (out_valid && !prev_ov) begin
          if (acc_q.size() == 0) chk("latency_no_accept", 32'd1, 32'd0);
          else begin
            t = acc_q.pop_front();
            chk("latency", 32'(cyc - t), 32'(LAT));
          end
        end
        if (out_valid) chk("in_ready_in_done", 32'(in_ready), 32'd0);
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) chk("unexpected_output", 32'd1, 32'd0);
          else begin
            e = exp_q.pop_front();
            chk("diff", 32'(diff), 32'(e[W+1:2]));
            chk("bout", 32'(bout), 32'(e[1]));
            chk("ovf",  32'(ovf),  32'(e[0]));
          end
        end
        prev_ov = out_valid;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] x, input logic [W-1:0] y);
    logic acc;
    int k;
    in_valid = 1'b1;
    a = x;
    b = y;
    k = 0;
    do begin
      acc = in_ready;
      tick();
      k++;
    end while (!acc && k < 200);
    if (!acc) chk("send_timeout", 32'd1, 32'd0);
    in_valid = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 200) begin
      tick();
      k++;
    end
    if (exp_q.size() != 0) chk("drain_timeout", 32'(exp_q.size()), 32'd0);
    tick();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W+1:0] e;
    logic [W-1:0] ta, tb;
    int k;
    logic [W-1:0] edge_vals[4];
    edge_vals[0] = 8'h00; edge_vals[1] = 8'h80; edge_vals[2] = 8'h7F; edge_vals[3] = 8'hFF;

    // Reset state
    rst_n = 1'b0;
    repeat (3) tick();
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_outs", 32'({diff, bout, ovf}), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("in_ready_after_rst", 32'(in_ready), 32'd1);

    // Directed vectors
    out_ready = 1'b1;
    send(8'h05, 8'h03); drain();
    send(8'h03, 8'h05); drain();
    send(8'h00, 8'h00); drain();
    send(8'h80, 8'h01); drain();
    send(8'h7F, 8'hFF); drain();

    // Backpressure in DONE with in_valid toggling
    out_ready = 1'b0;
    send(8'h5A, 8'hC3);
    e = model(8'h5A, 8'hC3);
    k = 0;
    while (!out_valid && k < 50) begin tick(); k++; end
    chk("bp_reach_done", 32'(out_valid), 32'd1);
    for (int i = 0; i < 20; i++) begin
      in_valid = i[0];
      a = W'($urandom);
      b = W'($urandom);
      tick();
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_hold", 32'({diff, bout, ovf}), 32'(e));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain();
    send(8'h10, 8'h20); drain();

    // Abort during RUN bit 4
    send(8'h12, 8'h34);
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    acc_q.delete();
    chk("abort_in_ready", 32'(in_ready), 32'd0);
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_outs", 32'({diff, bout, ovf}), 32'd0);
    repeat (2) tick();
    chk("abort_hold_outs", 32'({diff, bout, ovf, out_valid, in_ready}), 32'd0);
    rst_n = 1'b1;
    tick();
    send(8'hFF, 8'h01); drain();

    // Random traffic with random backpressure
    k = n_acc + 3000;
    while (n_acc < k && cyc < 80000) begin
      in_valid = ($urandom_range(3) != 0);
      ta = W'($urandom);
      tb = W'($urandom);
      if ($urandom_range(7) == 0) ta = edge_vals[$urandom_range(3)];
      if ($urandom_range(7) == 0) tb = edge_vals[$urandom_range(3)];
      a = ta;
      b = tb;
      out_ready = ($urandom_range(3) != 0);
      tick();
    end
    chk("random_count_reached", 32'(n_acc >= k), 32'd1);
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain();
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
